// File: rtl/counter_arbiter.sv
// rtl/counter_arbiter.sv - round-robin arbiter owning one shared programmable modulo counter
// Grants the counter to one requester at a time and reports completion or abort with a pulse.
module counter_arbiter #(
  parameter  int SIZE = 3,
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] maxval,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic [SIZE-1:0]      count,
  output logic                 done,
  output logic [IDW-1:0]       done_id,
  output logic                 abort
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  owner_q;
  logic [SIZE-1:0] mreg_q;
  logic [NREQ-1:0] gnt_q;
  logic            busy_q;
  logic [SIZE-1:0] count_q;
  logic            done_q;
  logic [IDW-1:0]  done_id_q;
  logic            abort_q;

  logic [IDW-1:0]  win_idx;
  logic [IDW:0]    cand;
  logic            found;
  logic [IDW-1:0]  ptr_d;

  // Rotating first-match search starting at ptr_q; cand is kept below NREQ for any NREQ.
  always_comb begin
    win_idx = ptr_q;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && req[cand[IDW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[IDW-1:0];
      end
    end
  end

  assign ptr_d = (owner_q == IDW'(NREQ-1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      mreg_q    <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q <= RUN;
            owner_q <= win_idx;
            gnt_q   <= NREQ'(1) << win_idx;
            busy_q  <= 1'b1;
            mreg_q  <= maxval[win_idx*SIZE +: SIZE];
            count_q <= '0;
          end
        end
        RUN: begin
          // Completion wins over a request dropped in the final cycle.
          if (count_q == mreg_q) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            done_q    <= 1'b1;
            done_id_q <= owner_q;
            ptr_q     <= ptr_d;
          end else if (!req[owner_q]) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            abort_q   <= 1'b1;
            done_id_q <= owner_q;
            ptr_q     <= ptr_d;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign count   = count_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign abort   = abort_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb/tb_counter_arbiter.sv - directed and randomized bench for counter_arbiter
// The random phase compares against a transaction-level model tracking owner and elapsed cycles.
module tb_counter_arbiter;
  localparam int SIZE = 3;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] maxval;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic [SIZE-1:0]      count;
  logic                 done;
  logic [IDW-1:0]       done_id;
  logic                 abort;

  int checks = 0;
  int errors = 0;

  bit m_active, m_done, m_abort;
  int m_owner, m_ptr, m_target, m_elapsed, m_id;

  counter_arbiter #(.SIZE(SIZE), .NREQ(NREQ)) dut (
    .clk(clk), .reset(reset), .req(req), .maxval(maxval), .gnt(gnt), .busy(busy),
    .count(count), .done(done), .done_id(done_id), .abort(abort)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_active = 0; m_done = 0; m_abort = 0;
    m_owner = 0; m_ptr = 0; m_target = 0; m_elapsed = 0; m_id = 0;
  endtask

  function automatic int pick(int p, logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return p;
  endfunction

  // One clock edge: the model consumes the inputs the DUT samples at this edge.
  task automatic tick();
    m_done = 0; m_abort = 0;
    if (!m_active) begin
      if (req != '0) begin
        m_owner = pick(m_ptr, req);
        m_active = 1;
        m_target = int'(maxval[m_owner*SIZE +: SIZE]);
        m_elapsed = 0;
      end
    end else if (m_elapsed == m_target) begin
      m_active = 0; m_done = 1; m_id = m_owner; m_ptr = (m_owner + 1) % NREQ;
    end else if (!req[m_owner]) begin
      m_active = 0; m_abort = 1; m_id = m_owner; m_ptr = (m_owner + 1) % NREQ;
    end else begin
      m_elapsed++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic set_max(int i, int v);
    maxval[i*SIZE +: SIZE] = v[SIZE-1:0];
  endtask

  task automatic apply_reset();
    reset = 1'b0; req = '0; maxval = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if ({done, abort, done_id} !== 4'b0000) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {done, abort, done_id}); end
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0001; set_max(0, 6);
    tick();
    checks++; if (gnt !== 4'b0001 || busy !== 1'b1) begin errors++; $display("FAIL single_grant got gnt=%b busy=%b exp 0001/1", gnt, busy); end
    for (int i = 0; i <= 6; i++) begin
      checks++; if (count !== i[2:0] || gnt !== 4'b0001 || done !== 1'b0) begin
        errors++; $display("FAIL single_count got count=%0d gnt=%b done=%b exp %0d/0001/0", count, gnt, done, i);
      end
      if (i == 6) req = 4'b0000;
      tick();
    end
    checks++; if (done !== 1'b1 || abort !== 1'b0 || done_id !== 2'd0) begin errors++; $display("FAIL single_done got done=%b abort=%b id=%0d exp 1/0/0", done, abort, done_id); end
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL single_release got gnt=%b busy=%b count=%0d exp 0/0/0", gnt, busy, count); end
    tick();
    checks++; if (done !== 1'b0 || gnt !== 4'b0000 || count !== 3'd0) begin errors++; $display("FAIL single_idle got done=%b gnt=%b count=%0d exp 0/0/0", done, gnt, count); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] one = 4'b0001;
    apply_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_max(i, 2);
    tick();
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c <= 2; c++) begin
        checks++; if (gnt !== (one << (g % NREQ)) || count !== c[2:0]) begin
          errors++; $display("FAIL rr_run got gnt=%b count=%0d exp %b/%0d", gnt, count, one << (g % NREQ), c);
        end
        tick();
      end
      checks++; if (done !== 1'b1 || done_id !== (g % NREQ) || gnt !== 4'b0000) begin
        errors++; $display("FAIL rr_done got done=%b id=%0d gnt=%b exp 1/%0d/0000", done, done_id, gnt, g % NREQ);
      end
      tick();
    end
  endtask

  task automatic test_zero_max();
    apply_reset();
    req = 4'b0100; set_max(2, 0);
    tick();
    checks++; if (gnt !== 4'b0100 || count !== 3'd0) begin errors++; $display("FAIL zero_grant got gnt=%b count=%0d exp 0100/0", gnt, count); end
    req = 4'b0000;
    tick();
    checks++; if (done !== 1'b1 || done_id !== 2'd2 || gnt !== 4'b0000 || abort !== 1'b0) begin
      errors++; $display("FAIL zero_done got done=%b id=%0d gnt=%b abort=%b exp 1/2/0000/0", done, done_id, gnt, abort);
    end
  endtask

  task automatic test_abort();
    apply_reset();
    req = 4'b0110; set_max(1, 6); set_max(2, 3);
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL abort_grant got %b exp 0010", gnt); end
    tick(); tick(); tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL abort_count got %0d exp 3", count); end
    req = 4'b0100;
    tick();
    checks++; if (abort !== 1'b1 || done !== 1'b0 || done_id !== 2'd1 || gnt !== 4'b0000) begin
      errors++; $display("FAIL abort_pulse got abort=%b done=%b id=%0d gnt=%b exp 1/0/1/0000", abort, done, done_id, gnt);
    end
    tick();
    checks++; if (gnt !== 4'b0100 || abort !== 1'b0) begin errors++; $display("FAIL abort_next got gnt=%b abort=%b exp 0100/0", gnt, abort); end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    req = 4'b1000; set_max(3, 7);
    tick(); tick(); tick(); tick(); tick();
    checks++; if (count !== 3'd4 || gnt !== 4'b1000) begin errors++; $display("FAIL midrun_pre got count=%0d gnt=%b exp 4/1000", count, gnt); end
    reset = 1'b0;
    #1;
    checks++; if ({gnt, busy, count, done, abort} !== 10'd0) begin
      errors++; $display("FAIL midrun_async got gnt=%b busy=%b count=%0d done=%b abort=%b exp all 0", gnt, busy, count, done, abort);
    end
    model_reset();
    #10;
    reset = 1'b1; req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL midrun_regrant got %b exp 0010", gnt); end
  endtask

  task automatic test_maxval_change();
    apply_reset();
    req = 4'b0001; set_max(0, 5);
    tick(); tick(); tick();
    set_max(0, 1);
    for (int c = 2; c <= 5; c++) begin
      checks++; if (count !== c[2:0] || done !== 1'b0) begin errors++; $display("FAIL mchg_count got count=%0d done=%b exp %0d/0", count, done, c); end
      if (c == 5) req = 4'b0000;
      tick();
    end
    checks++; if (done !== 1'b1 || done_id !== 2'd0) begin errors++; $display("FAIL mchg_done got done=%b id=%0d exp 1/0", done, done_id); end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] one = 4'b0001;
    logic [NREQ-1:0] exp_gnt;
    logic [SIZE-1:0] exp_count;
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) req = NREQ'($urandom);
      if ($urandom_range(0, 1) == 0) maxval = (NREQ*SIZE)'($urandom);
      tick();
      exp_gnt = m_active ? (one << m_owner) : '0;
      exp_count = m_active ? m_elapsed[SIZE-1:0] : '0;
      checks++; if (gnt !== exp_gnt || busy !== m_active || count !== exp_count) begin
        errors++; $display("FAIL rand_run cyc=%0d got gnt=%b busy=%b count=%0d exp %b/%b/%0d", n, gnt, busy, count, exp_gnt, m_active, exp_count);
      end
      checks++; if (done !== m_done || abort !== m_abort) begin
        errors++; $display("FAIL rand_pulse cyc=%0d got done=%b abort=%b exp %b/%b", n, done, abort, m_done, m_abort);
      end
      if (m_done || m_abort) begin
        checks++; if (done_id !== m_id[IDW-1:0]) begin errors++; $display("FAIL rand_id cyc=%0d got %0d exp %0d", n, done_id, m_id); end
      end
    end
  endtask

  initial begin
    reset = 1'b0; req = '0; maxval = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_max();
    test_abort();
    test_reset_midrun();
    test_maxval_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
